seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEGSCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
    parameter int unsigned DWELL_TICKS = 4,
    parameter int unsigned BLANK_TICKS = 1,
    parameter int unsigned NR_DIGITS   = 8
) (
    input  logic        GlobalClock,
    input  logic        RST,
    input  logic        Tick,
    input  logic        Enable,
    input  logic [31:0] Value,
    input  logic [7:0]  DP,
    input  logic        Load,
    output logic [7:0]  NA,
    output logic [7:0]  SEG,
    output logic        FrameDone
);

    localparam logic [7:0] DwellLast = 8'(DWELL_TICKS - 1);
    localparam logic [7:0] BlankLast = (BLANK_TICKS == 0) ? 8'd0 : 8'(BLANK_TICKS - 1);
    localparam logic [2:0] LastIdx   = 3'(NR_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StLit, StBlank} state_t;

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [7:0]  r_cnt;
    logic [31:0] r_pend_val;
    logic [7:0]  r_pend_dp;
    logic [31:0] r_disp_val;
    logic [7:0]  r_disp_dp;
    logic        r_dirty;
    logic [7:0]  r_na;
    logic [7:0]  r_seg;
    logic        r_frame_done;

    state_t      w_state_nxt;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_advance;
    logic        w_start;
    logic        w_frame_done_nxt;
    logic [31:0] w_disp_val_nxt;
    logic [7:0]  w_disp_dp_nxt;
    logic        w_show;
    logic [7:0]  w_na_nxt;
    logic [7:0]  w_seg_nxt;

    function automatic logic [6:0] f_hex(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SEGSCAN_LZ_BLANK_EN
    logic [2:0] r_top;
    logic [2:0] w_top_nxt;

    function automatic logic [2:0] f_top(input logic [31:0] v);
        logic [2:0] t;
        t = 3'd0;
        for (int i = 0; i < int'(NR_DIGITS); i++) begin
            if (v[4*i +: 4] != 4'h0) t = 3'(i);
        end
        return t;
    endfunction
`endif

    // Next-state: only a Tick can move the scan; the index advances at slot end.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_cnt_nxt        = r_cnt;
        w_advance        = 1'b0;
        w_start          = 1'b0;
        w_frame_done_nxt = 1'b0;
        if (Tick) begin
            case (r_state)
                StIdle: begin
                    if (Enable) begin
                        w_state_nxt = StLit;
                        w_idx_nxt   = 3'd0;
                        w_cnt_nxt   = 8'd0;
                        w_start     = 1'b1;
                    end
                end
                StLit: begin
                    if (r_cnt == DwellLast) begin
                        w_cnt_nxt = 8'd0;
                        if (BLANK_TICKS == 0) w_advance = 1'b1;
                        else                  w_state_nxt = StBlank;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                StBlank: begin
                    if (r_cnt == BlankLast) begin
                        w_cnt_nxt = 8'd0;
                        w_advance = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
        if (w_advance) begin
            if (r_idx == LastIdx) begin
                w_idx_nxt        = 3'd0;
                w_frame_done_nxt = 1'b1;
            end else begin
                w_idx_nxt = r_idx + 3'd1;
            end
            if (!Enable) begin
                w_state_nxt = StIdle;
                w_idx_nxt   = 3'd0;
            end else begin
                w_state_nxt = StLit;
                w_start     = (r_idx == LastIdx);
            end
        end
    end

    // Frame-start copy; outputs are decoded from the post-copy display value.
    always_comb begin
        w_disp_val_nxt = (w_start && r_dirty) ? r_pend_val : r_disp_val;
        w_disp_dp_nxt  = (w_start && r_dirty) ? r_pend_dp  : r_disp_dp;
`ifdef SEGSCAN_LZ_BLANK_EN
        w_top_nxt = w_start ? f_top(w_disp_val_nxt) : r_top;
        w_show    = (w_idx_nxt <= w_top_nxt) || w_disp_dp_nxt[w_idx_nxt];
`else
        w_show    = 1'b1;
`endif
        w_na_nxt  = 8'hFF;
        w_seg_nxt = 8'hFF;
        if (w_state_nxt == StLit && w_show) begin
            w_na_nxt  = ~(8'h01 << w_idx_nxt);
            w_seg_nxt = {~w_disp_dp_nxt[w_idx_nxt], f_hex(w_disp_val_nxt[{w_idx_nxt, 2'b00} +: 4])};
        end
    end

    always_ff @(posedge GlobalClock or negedge RST) begin
        if (!RST) begin
            r_state      <= StIdle;
            r_idx        <= 3'd0;
            r_cnt        <= 8'd0;
            r_pend_val   <= 32'd0;
            r_pend_dp    <= 8'd0;
            r_disp_val   <= 32'd0;
            r_disp_dp    <= 8'd0;
            r_dirty      <= 1'b0;
            r_na         <= 8'hFF;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
`ifdef SEGSCAN_LZ_BLANK_EN
            r_top        <= 3'd0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_disp_val   <= w_disp_val_nxt;
            r_disp_dp    <= w_disp_dp_nxt;
            r_na         <= w_na_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_frame_done_nxt;
`ifdef SEGSCAN_LZ_BLANK_EN
            r_top        <= w_top_nxt;
`endif
            // A Load coinciding with the frame-start copy keeps dirty set.
            if (Load) begin
                r_pend_val <= Value;
                r_pend_dp  <= DP;
                r_dirty    <= 1'b1;
            end else if (w_start) begin
                r_dirty    <= 1'b0;
            end
        end
    end

    assign NA        = r_na;
    assign SEG       = r_seg;
    assign FrameDone = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (DWELL=4, BLANK=1, 8 digits: 40 Ticks/frame).
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [31:0] val = 32'd0;
    logic [7:0]  dp = 8'd0;
    logic [7:0]  na;
    logic [7:0]  seg;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;
    int fd_cnt = 0;
    int fd_base = 0;
    int tk = 0;

    seg_scan_ctrl #(
        .DWELL_TICKS(4),
        .BLANK_TICKS(1),
        .NR_DIGITS  (8)
    ) dut (
        .GlobalClock(clk),
        .RST        (rst_n),
        .Tick       (tick),
        .Enable     (en),
        .Value      (val),
        .DP         (dp),
        .Load       (load),
        .NA         (na),
        .SEG        (seg),
        .FrameDone  (frame_done)
    );

    always #5 clk = ~clk;

    // Frame-done pulse counter and one-hot-low invariant on NA.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        vectors++;
        if ($countones(~na) > 1) begin
            miscompares++;
            $display("FAIL na_onehot NA=%h has more than one digit enabled", na);
        end
    end

    // Tick tasks assume they are entered on a negedge and return on one.
    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        tk++;
    endtask

    task automatic tick_to(input int n);
        while (tk < n) do_tick();
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] d);
        val  = v;
        dp   = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick  = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (6) begin
            tick = ~tick;
            @(negedge clk);
        end
        tick = 1'b0;
        vectors++;
        if ({na, seg, frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs NA/SEG/FD=%h/%h/%b want FF/FF/0", na, seg, frame_done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({na, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL idle_after_release NA/SEG=%h/%h want FF/FF", na, seg);
        end
        tk = -1;
        do_tick();
        vectors++;
        if ({na, seg} !== 16'hFEC0) begin
            miscompares++;
            $display("FAIL first_tick NA/SEG=%h/%h want FE/C0", na, seg);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        tk = -1;
        do_tick();
        do_load(32'h12345678, 8'hFF);
        tick_to(2);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({na, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL async_reset_dark NA/SEG=%h/%h want FF/FF", na, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tk = -1;
        do_tick();
        vectors++;
        if ({na, seg} !== 16'hFEC0) begin
            miscompares++;
            $display("FAIL pending_lost NA/SEG=%h/%h want FE/C0", na, seg);
        end
    endtask

    task automatic test_load_frame();
        do_reset();
        en = 1'b1;
        tk = -1;
        do_tick();
        tick_to(7);
        do_load(32'h76543210, 8'h00);
        tick_to(10);
        vectors++;
        if ({na, seg} !== 16'hFBC0) begin
            miscompares++;
            $display("FAIL no_tear_mid_frame NA/SEG=%h/%h want FB/C0", na, seg);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({na, seg} !== 16'hFBC0) begin
            miscompares++;
            $display("FAIL hold_without_tick NA/SEG=%h/%h want FB/C0", na, seg);
        end
        tick_to(39);
        vectors++;
        if ({na, seg, frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
            miscompares++;
            $display("FAIL last_blank NA/SEG/FD=%h/%h/%b want FF/FF/0", na, seg, frame_done);
        end
        fd_base = fd_cnt;
        tick_to(40);
        vectors++;
        if ({na, seg, frame_done} !== {8'hFE, 8'hC0, 1'b1}) begin
            miscompares++;
            $display("FAIL frame2_start NA/SEG/FD=%h/%h/%b want FE/C0/1", na, seg, frame_done);
        end
        tick_to(45);
        vectors++;
        if ({na, seg} !== 16'hFDF9) begin
            miscompares++;
            $display("FAIL new_digit1 NA/SEG=%h/%h want FD/F9", na, seg);
        end
        tick_to(75);
        vectors++;
        if ({na, seg} !== 16'h7FF8) begin
            miscompares++;
            $display("FAIL new_digit7 NA/SEG=%h/%h want 7F/F8", na, seg);
        end
        tick_to(80);
        @(negedge clk);
        vectors++;
        if ((fd_cnt - fd_base) !== 2 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done_rate pulses=%0d fd=%b want 2 pulses, fd=0",
                     fd_cnt - fd_base, frame_done);
        end
    endtask

    task automatic test_dp();
        do_reset();
        do_load(32'h88888888, 8'h04);
        en = 1'b1;
        tk = -1;
        do_tick();
        vectors++;
        if ({na, seg} !== 16'hFE80) begin
            miscompares++;
            $display("FAIL dp_digit0 NA/SEG=%h/%h want FE/80", na, seg);
        end
        tick_to(10);
        vectors++;
        if ({na, seg} !== 16'hFB00) begin
            miscompares++;
            $display("FAIL dp_digit2 NA/SEG=%h/%h want FB/00", na, seg);
        end
        tick_to(14);
        vectors++;
        if ({na, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL dp_blank NA/SEG=%h/%h want FF/FF", na, seg);
        end
        tick_to(15);
        vectors++;
        if ({na, seg} !== 16'hF780) begin
            miscompares++;
            $display("FAIL dp_digit3 NA/SEG=%h/%h want F7/80", na, seg);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        en = 1'b1;
        tk = -1;
        do_tick();
        tick_to(15);
        en = 1'b0;
        tick_to(18);
        vectors++;
        if ({na, seg} !== 16'hF7C0) begin
            miscompares++;
            $display("FAIL slot_completes NA/SEG=%h/%h want F7/C0", na, seg);
        end
        tick_to(19);
        vectors++;
        if ({na, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL drop_blank NA/SEG=%h/%h want FF/FF", na, seg);
        end
        tick_to(22);
        vectors++;
        if ({na, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL held_idle NA/SEG=%h/%h want FF/FF", na, seg);
        end
        en = 1'b1;
        do_tick();
        vectors++;
        if ({na, seg} !== 16'hFEC0) begin
            miscompares++;
            $display("FAIL restart_idx0 NA/SEG=%h/%h want FE/C0", na, seg);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_load(32'h11111111, 8'h00);
        en = 1'b1;
        tk = -1;
        do_tick();
        vectors++;
        if ({na, seg} !== 16'hFEF9) begin
            miscompares++;
            $display("FAIL b2b_frame1 NA/SEG=%h/%h want FE/F9", na, seg);
        end
        tick_to(20);
        do_load(32'h33333333, 8'h00);
        tick_to(39);
        // Load lands on the same edge as the frame-start copy.
        val  = 32'h22222222;
        load = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        load = 1'b0;
        tick = 1'b0;
        tk++;
        vectors++;
        if ({na, seg} !== 16'hFEB0) begin
            miscompares++;
            $display("FAIL b2b_frame2_d0 NA/SEG=%h/%h want FE/B0", na, seg);
        end
        tick_to(45);
        vectors++;
        if ({na, seg} !== 16'hFDB0) begin
            miscompares++;
            $display("FAIL b2b_frame2_d1 NA/SEG=%h/%h want FD/B0", na, seg);
        end
        tick_to(80);
        vectors++;
        if ({na, seg} !== 16'hFEA4) begin
            miscompares++;
            $display("FAIL b2b_frame3_d0 NA/SEG=%h/%h want FE/A4", na, seg);
        end
        tick_to(85);
        vectors++;
        if ({na, seg} !== 16'hFDA4) begin
            miscompares++;
            $display("FAIL b2b_frame3_d1 NA/SEG=%h/%h want FD/A4", na, seg);
        end
    endtask

    task automatic test_lz();
        logic [15:0] exp_d2;
        logic [15:0] exp_d7;
`ifdef SEGSCAN_LZ_BLANK_EN
        exp_d2 = 16'hFFFF;
        exp_d7 = 16'hFFFF;
`else
        exp_d2 = 16'hFBC0;
        exp_d7 = 16'h7FC0;
`endif
        do_reset();
        do_load(32'h000000A5, 8'h00);
        en = 1'b1;
        tk = -1;
        do_tick();
        vectors++;
        if ({na, seg} !== 16'hFE92) begin
            miscompares++;
            $display("FAIL lz_digit0 NA/SEG=%h/%h want FE/92", na, seg);
        end
        tick_to(5);
        vectors++;
        if ({na, seg} !== 16'hFD88) begin
            miscompares++;
            $display("FAIL lz_digit1 NA/SEG=%h/%h want FD/88", na, seg);
        end
        tick_to(10);
        vectors++;
        if ({na, seg} !== exp_d2) begin
            miscompares++;
            $display("FAIL lz_digit2 NA/SEG=%h/%h want %h", na, seg, exp_d2);
        end
        tick_to(35);
        vectors++;
        if ({na, seg} !== exp_d7) begin
            miscompares++;
            $display("FAIL lz_digit7 NA/SEG=%h/%h want %h", na, seg, exp_d7);
        end
        tick_to(40);
        vectors++;
        if ({na, seg, frame_done} !== {8'hFE, 8'h92, 1'b1}) begin
            miscompares++;
            $display("FAIL lz_frame_period NA/SEG/FD=%h/%h/%b want FE/92/1", na, seg, frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_load_frame();
        test_dp();
        test_enable_drop();
        test_back_to_back();
        test_lz();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
